// File: rtl/okand_host_link.sv
// Host link to the serial AND engine: buffers operand pairs, shifts 32 bits out, and collects the 16-bit result.
// A pair is popped one edge after it is pushed; in_ready = !full; HOLD waits on res_ready. OKAND_HOST_LINK_TIMEOUT_EN adds a WAIT watchdog.
module okand_host_link #(
  parameter int WIDTH          = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             pc_clk,
  input  logic             pc_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_op_1,
  input  logic [WIDTH-1:0] in_op_2,
  output logic             pc_data,
  output logic             pc_valid,
  input  logic             fpga_data,
  input  logic             fpga_valid,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy,
  output logic             err
);
  localparam int          FW       = 2 * WIDTH;
  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH    = (AW + 1)'(FIFO_DEPTH);
  localparam logic [4:0]  LAST_BIT = 5'(FW - 1);
  localparam logic [3:0]  LAST_RES = 4'(WIDTH - 1);

  if (WIDTH != 16 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1)
    begin : g_bad_cfg
      $error("okand_host_link: unsupported parameter set");
    end

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_HOLD} state_t;

  state_t        state;
  logic [FW-1:0] shift;
  logic [4:0]    bit_cnt;
  logic [3:0]    res_cnt;

  logic [FW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  logic          empty;

  assign in_ready = (count != DEPTH);
  assign empty    = (count == '0);
  assign push     = in_valid && in_ready;
  assign pop      = (state == S_IDLE) && !empty;
  assign busy     = (state != S_IDLE) || !empty;

  // Storage has no reset: emptiness is carried entirely by the pointers and count.
  always_ff @(posedge pc_clk) begin
    if (push) mem[wr_ptr] <= {in_op_2, in_op_1};
  end

  always_ff @(posedge pc_clk or posedge pc_rst) begin
    if (pc_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef OKAND_HOST_LINK_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wdog;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge pc_clk or posedge pc_rst) begin
    if (pc_rst) begin
      state     <= S_IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      res_cnt   <= '0;
      pc_data   <= 1'b0;
      pc_valid  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
`ifdef OKAND_HOST_LINK_TIMEOUT_EN
      wdog      <= '0;
      err       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            // Bit 0 goes straight onto the wire; the register holds what is still to send.
            shift    <= {1'b0, mem[rd_ptr][FW-1:1]};
            pc_data  <= mem[rd_ptr][0];
            pc_valid <= 1'b1;
            bit_cnt  <= '0;
            state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (bit_cnt == LAST_BIT) begin
            pc_valid <= 1'b0;
            pc_data  <= 1'b0;
            res_cnt  <= '0;
`ifdef OKAND_HOST_LINK_TIMEOUT_EN
            wdog     <= '0;
`endif
            state    <= S_WAIT;
          end else begin
            pc_data <= shift[0];
            shift   <= shift >> 1;
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        S_WAIT: begin
          if (fpga_valid) begin
            res_data[res_cnt] <= fpga_data;
            res_cnt           <= res_cnt + 4'd1;
            if (res_cnt == LAST_RES) begin
              res_valid <= 1'b1;
              state     <= S_HOLD;
            end
          end
`ifdef OKAND_HOST_LINK_TIMEOUT_EN
          wdog <= wdog + 16'd1;
          // Completing the final bit on the deadline cycle wins over the timeout.
          if (wdog == TO_LAST && !(fpga_valid && res_cnt == LAST_RES)) begin
            err     <= 1'b1;
            res_cnt <= '0;
            state   <= S_IDLE;
          end
`endif
        end
        S_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_okand_host_link.sv
// Directed bench for okand_host_link with a behavioural serial AND engine on the far side of the link.
`timescale 1ns/1ps
module tb_okand_host_link;
  logic        pc_clk = 1'b0;
  logic        pc_rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_op_1 = '0;
  logic [15:0] in_op_2 = '0;
  logic        pc_data;
  logic        pc_valid;
  logic        fpga_data;
  logic        fpga_valid;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic        busy;
  logic        err;

  logic eng_vld = 1'b0, eng_dat = 1'b0;
  logic stray_vld = 1'b0, stray_dat = 1'b0;
  assign fpga_valid = eng_vld | stray_vld;
  assign fpga_data  = eng_dat | stray_dat;

  okand_host_link dut (
    .pc_clk(pc_clk), .pc_rst(pc_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op_1(in_op_1), .in_op_2(in_op_2),
    .pc_data(pc_data), .pc_valid(pc_valid),
    .fpga_data(fpga_data), .fpga_valid(fpga_valid),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .err(err)
  );

  always #5 pc_clk = ~pc_clk;

  // Engine model: gathers a 32-bit frame, then returns ret_bits of (low & high), LSB first.
  logic [31:0] frame_sr = '0;
  logic [31:0] last_frame = '0;
  logic [15:0] ret_word = '0;
  int          rx_cnt = 0;
  int          tx_idx = 0;
  int          ret_bits = 16;
  bit          tx_active = 1'b0;

  always @(negedge pc_clk or posedge pc_rst) begin
    if (pc_rst) begin
      rx_cnt = 0; tx_idx = 0; tx_active = 1'b0; eng_vld = 1'b0; eng_dat = 1'b0;
    end else if (tx_active) begin
      if (tx_idx < ret_bits) begin
        eng_vld = 1'b1; eng_dat = ret_word[tx_idx[3:0]]; tx_idx++;
      end else begin
        eng_vld = 1'b0; eng_dat = 1'b0; tx_active = 1'b0;
      end
    end else if (pc_valid) begin
      frame_sr[rx_cnt[4:0]] = pc_data;
      rx_cnt++;
      if (rx_cnt == 32) begin
        last_frame = frame_sr;
        ret_word   = frame_sr[15:0] & frame_sr[31:16];
        tx_active  = 1'b1; tx_idx = 0; rx_cnt = 0;
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pc_clk);
    #1;
  endtask

  task automatic wait_res(input string tag, input int limit);
    int n;
    n = 0;
    while (res_valid !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    check({tag, "_res_valid"}, 32'(res_valid), 32'd1);
  endtask

  task automatic run_txn(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
    in_valid = 1'b1; in_op_1 = a; in_op_2 = b;
    tick();
    in_valid = 1'b0;
    wait_res(tag, 200);
    check({tag, "_frame"}, last_frame, {b, a});
    check({tag, "_data"}, 32'(res_data), 32'(exp));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_res_drop"}, 32'(res_valid), 32'd0);
  endtask

  logic [15:0] bp_a [6] = '{16'h1234, 16'hAAAA, 16'hFFFF, 16'h0F0F, 16'hC3C3, 16'h7777};
  logic [15:0] bp_b [6] = '{16'hFF00, 16'h5555, 16'hA5A5, 16'h00FF, 16'h8181, 16'h7777};
  logic [15:0] bp_e [5] = '{16'h1200, 16'h0000, 16'hA5A5, 16'h000F, 16'h8181};

  initial begin
    int          nvld, acc, got, n;
    logic [31:0] bits;
    logic [15:0] held;
    logic        stable, pv;

    #3;
    check("rst_pc_valid", 32'(pc_valid), 32'd0);
    check("rst_pc_data", 32'(pc_data), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    repeat (2) @(posedge pc_clk);
    #1;
    pc_rst = 1'b0;
    tick();

    // Single transaction with an explicit look at the serial frame timing.
    in_valid = 1'b1; in_op_1 = 16'hF0F0; in_op_2 = 16'h3C3C;
    tick();
    in_valid = 1'b0;
    check("t1_no_bypass", 32'(pc_valid), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    tick();
    nvld = 0; bits = '0;
    for (int i = 0; i < 32; i++) begin
      if (pc_valid) begin
        bits[i[4:0]] = pc_data;
        nvld++;
      end
      tick();
    end
    check("t1_pc_valid_cycles", 32'(nvld), 32'd32);
    check("t1_bits", bits, 32'h3C3C_F0F0);
    check("t1_pc_valid_end", 32'(pc_valid), 32'd0);
    wait_res("t1", 100);
    check("t1_data", 32'(res_data), 32'h3030);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("t1_res_drop", 32'(res_valid), 32'd0);

    // Backpressure: six offered with results stalled; five fit.
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_op_1 = bp_a[i]; in_op_2 = bp_b[i];
      if (i == 5) check("bp_in_ready_full", 32'(in_ready), 32'd0);
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    check("bp_accepted", 32'(acc), 32'd5);
    wait_res("bp0", 200);
    check("bp_res0", 32'(res_data), 32'(bp_e[0]));

    // Hold the first result for 10 cycles.
    held = res_data; stable = 1'b1; pv = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (res_data !== held || res_valid !== 1'b1) stable = 1'b0;
      if (pc_valid !== 1'b0) pv = 1'b1;
    end
    check("hold_stable", 32'(stable), 32'd1);
    check("hold_pc_valid", 32'(pv), 32'd0);
    res_ready = 1'b1;
    tick();
    check("hs_res_drop", 32'(res_valid), 32'd0);
    check("hs_gap", 32'(pc_valid), 32'd0);
    tick();
    check("hs_next_frame", 32'(pc_valid), 32'd1);

    got = 0; n = 0;
    while (got < 4 && n < 1000) begin
      if (res_valid && res_ready) begin
        check($sformatf("bp_res%0d", got + 1), 32'(res_data), 32'(bp_e[got + 1]));
        got++;
      end
      tick();
      n++;
    end
    check("bp_result_count", 32'(got), 32'd4);
    repeat (40) tick();
    check("bp_drained", 32'(busy), 32'd0);
    res_ready = 1'b0;

    // Stray engine bits while idle must be ignored.
    stray_vld = 1'b1; stray_dat = 1'b1;
    repeat (3) tick();
    stray_vld = 1'b0; stray_dat = 1'b0;
    check("stray_busy", 32'(busy), 32'd0);
    check("stray_res_valid", 32'(res_valid), 32'd0);
    run_txn("stray", 16'hFFFF, 16'h0001, 16'h0001);

    // Reset after 10 bits of a frame with another pair queued.
    in_valid = 1'b1; in_op_1 = 16'h1111; in_op_2 = 16'h2222;
    tick();
    in_op_1 = 16'h3333; in_op_2 = 16'h4444;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    check("mid_send_active", 32'(pc_valid), 32'd1);
    pc_rst = 1'b1;
    #1;
    check("rst_mid_pc_valid", 32'(pc_valid), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_res_valid", 32'(res_valid), 32'd0);
    tick();
    pc_rst = 1'b0;
    tick();
    check("rst_mid_busy", 32'(busy), 32'd0);
    run_txn("post_rst", 16'h9999, 16'h0FF0, 16'h0990);

`ifdef OKAND_HOST_LINK_TIMEOUT_EN
    begin : to_blk
      logic seen;
      seen = 1'b0;
      ret_bits = 5;
      in_valid = 1'b1; in_op_1 = 16'hABCD; in_op_2 = 16'hFFFF;
      tick();
      in_op_1 = 16'h00FF; in_op_2 = 16'h0FF0;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 89; i++) begin
        if (res_valid) seen = 1'b1;
        tick();
      end
      check("to_not_early", 32'(err), 32'd0);
      for (int i = 0; i < 10; i++) begin
        if (res_valid) seen = 1'b1;
        tick();
      end
      check("to_err", 32'(err), 32'd1);
      check("to_no_res", 32'(seen), 32'd0);
      ret_bits = 16;
      wait_res("to_next", 200);
      check("to_next_data", 32'(res_data), 32'h00F0);
      check("to_err_sticky", 32'(err), 32'd1);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
    end
`else
    check("err_tied", 32'(err), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end
endmodule
